song_library: RTL and testbench

SONG_LIBRARY -- requirements
Module: song_library

---
 rtl/song_lib_pkg.sv | 65 ++++++
 rtl/song_library_tick_sync.sv | 26 ++
 rtl/song_library.sv | 181 ++++++++++++++++++
 tb/tb_song_library.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_lib_pkg.sv
// Shared constants, FSM state encoding and the constant song table for the
// read-only slots of the song library.
package song_lib_pkg;

  localparam logic [4:0] NOTE_REST = 5'd0;
  localparam logic [4:0] NOTE_END  = 5'h1F;
  localparam int         SONG_LEN  = 64;
  localparam int         ROM_SLOTS = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_REC  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Entries past the end of a listed melody read as the end marker.
  function automatic logic [4:0] rom_note(input logic [2:0] song, input logic [5:0] idx);
    logic [4:0] note;
    note = NOTE_END;
    case (song)
      3'd0: begin
        case (idx)
          6'd0:    note = 5'd1;
          6'd1:    note = 5'd3;
          6'd2:    note = 5'd5;
          6'd3:    note = 5'd8;
          6'd4:    note = 5'd12;
          default: note = NOTE_END;
        endcase
      end
      3'd1: begin
        case (idx)
          6'd0:    note = 5'd10;
          6'd1:    note = 5'd10;
          6'd2:    note = NOTE_REST;
          6'd3:    note = 5'd14;
          6'd4:    note = 5'd21;
          default: note = NOTE_END;
        endcase
      end
      3'd2: begin
        case (idx)
          6'd0:    note = 5'd5;
          6'd1:    note = 5'd3;
          6'd2:    note = 5'd1;
          default: note = NOTE_END;
        endcase
      end
      3'd3: note = NOTE_END;
      3'd4: begin
        if (idx < 6'd12) begin
          note = idx[0] ? NOTE_REST : 5'd17;
        end else begin
          note = NOTE_END;
        end
      end
      // Song 5 fills all 64 entries and never terminates on its own.
      3'd5: note = {1'b0, idx[3:0]} + 5'd1;
      default: note = NOTE_END;
    endcase
    return note;
  endfunction

endpackage

// File: rtl/song_library_tick_sync.sv
// Two-flop synchronizer for the player's tempo strobe followed by a rising
// edge detector producing a registered single-cycle tick.
module tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic lib_clk,
  output logic tick
);

  logic [2:0] sync_r;
  logic       tick_r;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= 3'b000;
      tick_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[1:0], lib_clk};
      tick_r <= sync_r[1] & ~sync_r[2];
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/song_library.sv
// Eight-slot note library: slots 0-5 play from a constant table, slots 6-7
// can be recorded one note per tempo tick and played back.
module song_library
  import song_lib_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       lib_clk,
  input  logic       lib_RorW,
  input  logic       lib_back_to,
  input  logic [2:0] lib_song_select,
  input  logic [4:0] lib_wr_note,
  output logic [4:0] lib_note,
  output logic [5:0] lib_ptr,
  output logic       song_end,
  output logic       busy
);

  state_t     state_r, state_s;
  logic [5:0] ptr_r, ptr_s, nxt_idx_s;
  logic [4:0] note_r, note_s;
  logic [2:0] sel_r, sel_s;
  logic       song_end_r, busy_r;
  logic       tick_s;
  logic       wr_en_s;
  logic [4:0] wr_data_s;
  logic [4:0] fetch_s, first_s;
  logic [4:0] ram_r [2][SONG_LEN];

  tick_sync u_tick_sync (
    .clk     (clk),
    .rst     (rst),
    .lib_clk (lib_clk),
    .tick    (tick_s)
  );

  assign nxt_idx_s = ptr_r + 6'd1;

  // Read ports: the next entry of the latched song, and entry 0 of the selected song.
  always_comb begin
    if (sel_r < 3'(ROM_SLOTS)) begin
      fetch_s = rom_note(sel_r, nxt_idx_s);
    end else begin
      fetch_s = ram_r[sel_r[0]][nxt_idx_s];
    end
    if (lib_song_select < 3'(ROM_SLOTS)) begin
      first_s = rom_note(lib_song_select, 6'd0);
    end else begin
      first_s = ram_r[lib_song_select[0]][6'd0];
    end
  end

  // Next-state, pointer, note and write-port decode.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    note_s    = note_r;
    sel_s     = sel_r;
    wr_en_s   = 1'b0;
    wr_data_s = NOTE_END;
    case (state_r)
      ST_IDLE: begin
        ptr_s  = 6'd0;
        note_s = NOTE_REST;
        if (lib_back_to) begin
          if (!lib_RorW) begin
            sel_s = lib_song_select;
            if (first_s == NOTE_END) begin
              state_s = ST_DONE;
              note_s  = NOTE_END;
            end else begin
              state_s = ST_PLAY;
              note_s  = first_s;
            end
          end else if (lib_song_select >= 3'(ROM_SLOTS)) begin
            sel_s   = lib_song_select;
            state_s = ST_REC;
            note_s  = lib_wr_note;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (!lib_back_to) begin
          state_s = ST_IDLE;
          ptr_s   = 6'd0;
          note_s  = NOTE_REST;
        end else if (tick_s) begin
          if ((ptr_r == 6'(SONG_LEN - 1)) || (fetch_s == NOTE_END)) begin
            state_s = ST_DONE;
            note_s  = NOTE_END;
          end else begin
            ptr_s  = nxt_idx_s;
            note_s = fetch_s;
          end
        end else begin
          state_s = ST_PLAY;
        end
      end
      ST_REC: begin
        note_s = lib_wr_note;
        if (!lib_back_to) begin
          // Abandoning a recording still terminates the song where it stopped.
          wr_en_s   = 1'b1;
          wr_data_s = NOTE_END;
          state_s   = ST_IDLE;
          ptr_s     = 6'd0;
          note_s    = NOTE_REST;
        end else if (tick_s) begin
          wr_en_s = 1'b1;
          if ((ptr_r == 6'(SONG_LEN - 1)) || (lib_wr_note == NOTE_END)) begin
            wr_data_s = NOTE_END;
            state_s   = ST_DONE;
            note_s    = NOTE_END;
          end else begin
            wr_data_s = lib_wr_note;
            ptr_s     = nxt_idx_s;
          end
        end else begin
          state_s = ST_REC;
        end
      end
      ST_DONE: begin
        note_s = NOTE_END;
        if (!lib_back_to) begin
          state_s = ST_IDLE;
          ptr_s   = 6'd0;
          note_s  = NOTE_REST;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        ptr_s   = 6'd0;
        note_s  = NOTE_REST;
      end
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ptr_r      <= 6'd0;
      note_r     <= NOTE_REST;
      sel_r      <= 3'd0;
      song_end_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      note_r     <= note_s;
      sel_r      <= sel_s;
      song_end_r <= (state_s == ST_DONE);
      busy_r     <= (state_s == ST_PLAY) || (state_s == ST_REC);
    end
  end

  // Recordable slots; the write enable is qualified so ROM slots are never addressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < SONG_LEN; i++) begin
          ram_r[s][i] <= NOTE_END;
        end
      end
    end else if (wr_en_s && (sel_r >= 3'(ROM_SLOTS))) begin
      ram_r[sel_r[0]][ptr_r] <= wr_data_s;
    end
  end

  assign lib_note = note_r;
  assign lib_ptr  = ptr_r;
  assign song_end = song_end_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_song_library.sv
// Randomized scoreboard bench for song_library: an event-level library model
// predicts every output change and a monitor matches them as they appear.
module tb_song_library;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lib_clk = 1'b0;
  logic       lib_RorW = 1'b0;
  logic       lib_back_to = 1'b0;
  logic [2:0] lib_song_select = 3'd0;
  logic [4:0] lib_wr_note = 5'd0;
  logic [4:0] lib_note;
  logic [5:0] lib_ptr;
  logic       song_end;
  logic       busy;

  song_library dut (
    .clk             (clk),
    .rst             (rst),
    .lib_clk         (lib_clk),
    .lib_RorW        (lib_RorW),
    .lib_back_to     (lib_back_to),
    .lib_song_select (lib_song_select),
    .lib_wr_note     (lib_wr_note),
    .lib_note        (lib_note),
    .lib_ptr         (lib_ptr),
    .song_end        (song_end),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0] note;
    logic [5:0] ptr;
    logic       send;
    logic       busy;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic mon_en = 1'b0;
  logic finish_req = 1'b0;
  logic mon_done = 1'b0;

  // ---------------- reference model (one call per stimulus event) ----------------
  localparam int END = 31;
  int mem [8][64];
  int m_mode;  // 0 idle, 1 playing, 2 recording, 3 finished
  int m_sel, m_ptr, m_note;
  int p_note, p_ptr, p_end, p_busy;

  task automatic m_init_rom();
    int s0 [5] = '{1, 3, 5, 8, 12};
    int s1 [5] = '{10, 10, 0, 14, 21};
    int s2 [3] = '{5, 3, 1};
    for (int s = 0; s < 8; s++)
      for (int i = 0; i < 64; i++) mem[s][i] = END;
    for (int i = 0; i < 5; i++) begin mem[0][i] = s0[i]; mem[1][i] = s1[i]; end
    for (int i = 0; i < 3; i++) mem[2][i] = s2[i];
    for (int i = 0; i < 12; i++) mem[4][i] = (i % 2 == 1) ? 0 : 17;
    for (int i = 0; i < 64; i++) mem[5][i] = (i % 16) + 1;
  endtask

  task automatic m_publish(input int due);
    int e_end, e_busy;
    e_end  = (m_mode == 3) ? 1 : 0;
    e_busy = (m_mode == 1 || m_mode == 2) ? 1 : 0;
    if (m_note != p_note || m_ptr != p_ptr || e_end != p_end || e_busy != p_busy) begin
      exp_q.push_back('{note: 5'(m_note), ptr: 6'(m_ptr), send: 1'(e_end),
                        busy: 1'(e_busy), due: due});
      p_note = m_note; p_ptr = m_ptr; p_end = e_end; p_busy = e_busy;
    end
  endtask

  task automatic m_reset();
    m_mode = 0; m_ptr = 0; m_note = 0;
    for (int s = 6; s < 8; s++)
      for (int i = 0; i < 64; i++) mem[s][i] = END;
  endtask

  task automatic m_go_idle();
    m_mode = 0; m_ptr = 0; m_note = 0;
  endtask

  task automatic m_start(input int sel, input int rorw, input int wr);
    if (m_mode == 0) begin
      if (rorw == 0) begin
        m_sel = sel; m_ptr = 0;
        if (mem[sel][0] == END) begin m_mode = 3; m_note = END; end
        else begin m_mode = 1; m_note = mem[sel][0]; end
      end else if (sel >= 6) begin
        m_sel = sel; m_ptr = 0; m_mode = 2; m_note = wr;
      end
    end
  endtask

  task automatic m_stop();
    if (m_mode == 2) mem[m_sel][m_ptr] = END;
    m_go_idle();
  endtask

  task automatic m_tick(input int wr);
    if (m_mode == 1) begin
      if (m_ptr == 63 || mem[m_sel][m_ptr + 1] == END) begin m_mode = 3; m_note = END; end
      else begin m_ptr = m_ptr + 1; m_note = mem[m_sel][m_ptr]; end
    end else if (m_mode == 2) begin
      if (m_ptr == 63 || wr == END) begin
        mem[m_sel][m_ptr] = END; m_mode = 3; m_note = END;
      end else begin
        mem[m_sel][m_ptr] = wr; m_ptr = m_ptr + 1;
      end
    end
  endtask

  // ---------------- stimulus helpers (called at the falling edge) ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_back_to(input logic b);
    lib_back_to = b;
    if (b) m_start(int'(lib_song_select), int'(lib_RorW), int'(lib_wr_note));
    else m_stop();
    m_publish(cyc + 1);
    cycles(1);
  endtask

  task automatic set_wr(input int w);
    lib_wr_note = 5'(w);
    if (m_mode == 2) m_note = w;
    m_publish(cyc + 1);
    cycles(1);
  endtask

  // One tempo pulse; its tick is consumed four cycles after the rise is driven.
  task automatic pulse();
    int d;
    if (m_mode != 0) begin
      lib_song_select = 3'($urandom);
      lib_RorW = 1'($urandom);
    end
    d = cyc;
    lib_clk = 1'b1;
    m_tick(int'(lib_wr_note));
    m_publish(d + 4);
    cycles($urandom_range(1, 3));
    lib_clk = 1'b0;
    cycles($urandom_range(4, 6));
  endtask

  // Pulse whose tick lands in the same cycle that lib_back_to drops.
  task automatic pulse_with_drop();
    int d;
    d = cyc;
    lib_clk = 1'b1;
    cycles(3);
    lib_back_to = 1'b0;
    m_stop();
    m_publish(d + 4);
    cycles(1);
    lib_clk = 1'b0;
    cycles(5);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    lib_back_to = 1'b0;
    m_reset();
    m_publish(cyc + 1);
    cycles(2);
    rst = 1'b0;
    cycles(1);
  endtask

  task automatic play(input int sel, input int n);
    lib_RorW = 1'b0;
    lib_song_select = 3'(sel);
    set_back_to(1'b1);
    repeat (n) pulse();
    set_back_to(1'b0);
  endtask

  function automatic int rnd_note();
    if ($urandom_range(0, 9) == 0) return END;
    return int'($urandom_range(0, 21));
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  initial begin : monitor
    logic [4:0] pn;
    logic [5:0] pp;
    logic pe, pb;
    exp_t e;
    wait (mon_en);
    @(negedge clk);
    check("reset_note", int'(lib_note), 0);
    check("reset_ptr", int'(lib_ptr), 0);
    check("reset_song_end", int'(song_end), 0);
    check("reset_busy", int'(busy), 0);
    pn = lib_note; pp = lib_ptr; pe = song_end; pb = busy;
    while (!finish_req) begin
      @(negedge clk);
      if (lib_note != pn || lib_ptr != pp || song_end != pe || busy != pb) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_change: got note=%0d ptr=%0d end=%0b busy=%0b at cycle %0d, expected no change",
                   lib_note, lib_ptr, song_end, busy, cyc);
        end else begin
          e = exp_q.pop_front();
          if (lib_note != e.note || lib_ptr != e.ptr || song_end != e.send ||
              busy != e.busy || cyc != e.due) begin
            miscompares++;
            $display("FAIL output_change: got note=%0d ptr=%0d end=%0b busy=%0b cycle=%0d, expected note=%0d ptr=%0d end=%0b busy=%0b cycle=%0d",
                     lib_note, lib_ptr, song_end, busy, cyc, e.note, e.ptr, e.send, e.busy, e.due);
          end
        end
        pn = lib_note; pp = lib_ptr; pe = song_end; pb = busy;
      end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing_change: got note=%0d ptr=%0d end=%0b busy=%0b at cycle %0d, expected note=%0d ptr=%0d end=%0b busy=%0b at cycle %0d",
                 lib_note, lib_ptr, song_end, busy, cyc, e.note, e.ptr, e.send, e.busy, e.due);
      end
    end
    check("pending_expectations", exp_q.size(), 0);
    mon_done = 1'b1;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // ---------------- directed then randomized stimulus ----------------
  initial begin : driver
    int r, n, sel;
    m_init_rom();
    m_reset();
    p_note = 0; p_ptr = 0; p_end = 0; p_busy = 0;
    cycles(3);
    rst = 1'b0;
    mon_en = 1'b1;
    cycles(2);

    // ROM song 2 with four pulses.
    play(2, 4);

    // Record 7,8,9 into slot 6, abandon, then replay.
    lib_RorW = 1'b1; lib_song_select = 3'd6; lib_wr_note = 5'd7;
    set_back_to(1'b1);
    pulse(); set_wr(8); pulse(); set_wr(9); pulse();
    set_back_to(1'b0);
    play(6, 4);

    // Record request on a ROM slot is refused; ROM still plays its table.
    lib_RorW = 1'b1; lib_song_select = 3'd1;
    set_back_to(1'b1);
    cycles(5);
    set_back_to(1'b0);
    play(1, 6);

    // Fill slot 7 completely, then replay it to the end.
    lib_RorW = 1'b1; lib_song_select = 3'd7;
    set_wr(4);
    set_back_to(1'b1);
    repeat (64) pulse();
    set_back_to(1'b0);
    play(7, 64);

    // Full-length ROM song ends at the last index; empty song ends at once.
    play(5, 65);
    play(3, 2);

    // Tick coincident with lib_back_to falling during playback.
    lib_RorW = 1'b0; lib_song_select = 3'd5;
    set_back_to(1'b1);
    repeat (3) pulse();
    pulse_with_drop();

    // Reset in the middle of a recording at index 10.
    lib_RorW = 1'b1; lib_song_select = 3'd6; lib_wr_note = 5'd3;
    set_back_to(1'b1);
    repeat (10) begin set_wr(int'($urandom_range(1, 21))); pulse(); end
    do_reset();
    play(6, 2);
    play(7, 2);

    // Randomized mix of playback, recording and refused recordings.
    for (int it = 0; it < 30; it++) begin
      r = int'($urandom_range(0, 3));
      if (r <= 1) begin
        sel = int'($urandom_range(0, 7));
        n = ($urandom_range(0, 7) == 0) ? 66 : int'($urandom_range(0, 20));
        play(sel, n);
      end else if (r == 2) begin
        lib_RorW = 1'b1;
        lib_song_select = 3'(6 + $urandom_range(0, 1));
        lib_wr_note = 5'(rnd_note());
        set_back_to(1'b1);
        n = int'($urandom_range(0, 20));
        repeat (n) begin
          if ($urandom_range(0, 2) == 0) set_wr(rnd_note());
          pulse();
        end
        if ($urandom_range(0, 4) == 0) do_reset();
        else set_back_to(1'b0);
      end else begin
        lib_RorW = 1'b1;
        lib_song_select = 3'($urandom_range(0, 5));
        set_back_to(1'b1);
        pulse();
        set_back_to(1'b0);
      end
    end

    cycles(8);
    finish_req = 1'b1;
    repeat (20) begin
      if (!mon_done) @(negedge clk);
    end
    if (!mon_done) begin
      $display("FAIL monitor_timeout: monitor did not complete, expected completion within 20 cycles");
      $fatal(1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
